// File: rtl/pet2001_prg_loader.sv
// PET 2001 PRG file loader: streams a .PRG image into main RAM over the
// DMA port while the CPU is held, then fixes up the BASIC end pointers.
module pet2001_prg_loader #(
    parameter logic [7:0]  PTR_BASE = 8'h2A,
    parameter logic [15:0] RAM_TOP  = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        PTR,
        FIN
    } state_t;

    state_t      r_state;
    logic        r_dl_prev;
    logic [15:0] r_wp;
    logic [15:0] r_end;
    logic        r_ovf;
    logic [2:0]  r_pidx;

    logic        w_rise;
    logic        w_rx_state;
    logic        w_take;
    logic        w_in_ram;
    logic [15:0] w_end;
    logic [7:0]  w_ptr_lo;

    assign w_rise     = dl_active & ~r_dl_prev;
    assign w_rx_state = (r_state == HDR_LO) |
                        (r_state == HDR_HI) |
                        (r_state == DATA);

    // A byte is only taken while the stream is still open and no
    // strobe is on the bus, which caps throughput at one byte per
    // two cycles.
    assign byte_ready = w_rx_state & ~dma_we & dl_active;
    assign w_take     = byte_valid & byte_ready;

    // Once anything has fallen off the top of RAM (including a
    // wrap through FFFF), every later byte stays suppressed.
    assign w_in_ram   = (r_wp < RAM_TOP) & ~r_ovf;

    // End pointer is clamped to the RAM top; at DATA entry wp holds
    // the load address, so an empty payload ends where it started.
    assign w_end      = (r_ovf | (r_wp >= RAM_TOP)) ? RAM_TOP : r_wp;

    assign w_ptr_lo   = PTR_BASE + {5'b0, r_pidx};

    // Loader FSM with registered DMA, hold, done and error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_dl_prev <= 1'b1;
            r_wp      <= 16'h0000;
            r_end     <= 16'h0000;
            r_ovf     <= 1'b0;
            r_pidx    <= 3'd0;
            dma_addr  <= 16'h0000;
            dma_din   <= 8'h00;
            dma_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_dl_prev <= dl_active;
            dma_we    <= 1'b0;
            done      <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state  <= HDR_LO;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        r_ovf    <= 1'b0;
                    end
                end
                HDR_LO: begin
                    if (!dl_active) begin
                        error   <= 1'b1;
                        r_state <= FIN;
                    end else if (w_take) begin
                        r_wp[7:0] <= byte_data;
                        r_state   <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (!dl_active) begin
                        error   <= 1'b1;
                        r_state <= FIN;
                    end else if (w_take) begin
                        r_wp[15:8] <= byte_data;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (!dl_active) begin
                        r_end   <= w_end;
                        r_pidx  <= 3'd0;
                        r_state <= PTR;
                    end else if (w_take) begin
                        r_wp <= r_wp + 16'd1;
                        if (w_in_ram) begin
                            dma_we   <= 1'b1;
                            dma_addr <= r_wp;
                            dma_din  <= byte_data;
                        end else begin
                            error <= 1'b1;
                            r_ovf <= 1'b1;
                        end
                    end
                end
                PTR: begin
                    dma_we   <= 1'b1;
                    dma_addr <= {8'h00, w_ptr_lo};
                    dma_din  <= r_pidx[0] ? r_end[15:8] : r_end[7:0];
                    r_pidx   <= r_pidx + 3'd1;
                    if (r_pidx == 3'd5) begin
                        r_state <= FIN;
                        done    <= ~error;
                    end
                end
                FIN: begin
                    cpu_hold <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet2001_prg_loader.sv
// Randomized bench for pet2001_prg_loader against a transfer-level
// model of RAM strobes, pointer fix-up, done and error.
module tb_pet2001_prg_loader;

    localparam int RAM_TOP = 32'h8000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;

    logic [23:0] obs[$];
    int          n_done = 0;
    int          n_overlap = 0;

    pet2001_prg_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dl_active (dl_active),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .dma_addr  (dma_addr),
        .dma_din   (dma_din),
        .dma_we    (dma_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dma_we) obs.push_back({dma_addr, dma_din});
        if (dma_we && byte_ready) n_overlap++;
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [7:0] b[$], input int gap_max,
                            input string tag);
        logic [23:0] exp[$];
        logic [15:0] e16;
        int          ld;
        int          np;
        int          endv;
        int          cnt;
        bit          eerr;
        bit          ok;
        int          lim;
        obs.delete();
        n_done = 0;
        eerr = 0;
        if (b.size() < 2) begin
            eerr = 1;
        end else begin
            ld = int'(b[0]) + 256 * int'(b[1]);
            np = b.size() - 2;
            for (int i = 0; i < np; i++) begin
                if (ld + i < RAM_TOP)
                    exp.push_back({16'(ld + i), b[i + 2]});
                else
                    eerr = 1;
            end
            endv = (ld + np < RAM_TOP) ? ld + np : RAM_TOP;
            e16 = 16'(endv);
            for (int k = 0; k < 6; k++)
                exp.push_back({8'h00, 8'(8'h2A + k),
                               (k % 2) ? e16[15:8] : e16[7:0]});
        end

        @(posedge clk); #1;
        dl_active = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < b.size(); i++) begin
            byte_valid = 1'b1;
            byte_data  = b[i];
            ok  = 0;
            lim = 0;
            while (!ok && lim < 40) begin
                @(negedge clk);
                ok = byte_ready;
                @(posedge clk); #1;
                lim++;
            end
            if (!ok) chk({tag, "_accept_timeout"}, 0, 1);
            if (gap_max > 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                end
            end
        end
        byte_valid = 1'b0;
        dl_active  = 1'b0;
        cnt = 0;
        ok  = 0;
        while (!ok && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            ok = !cpu_hold;
        end
        if (!ok) chk({tag, "_hold_timeout"}, 0, 1);
        if (b.size() < 2) chk({tag, "_hold_lat"}, cnt, 2);
        @(negedge clk);
        chk({tag, "_error"}, error, eerr);
        chk({tag, "_done"}, n_done, eerr ? 0 : 1);
        chk({tag, "_nstrobe"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            chk($sformatf("%s_s%0d", tag, i), obs[i], exp[i]);
    endtask

    initial begin
        logic [7:0] q[$];
        int         ld;
        int         np;
        int         mode;

        #2;
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", dma_we, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", dma_addr, 0);
        chk("rst_din", dma_din, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run_xfer(q, 2, "basic");
        q = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33};
        run_xfer(q, 1, "top");
        q = '{8'h01};
        run_xfer(q, 0, "hdr1");
        q = '{};
        run_xfer(q, 0, "hdr0");
        q = '{8'h00, 8'h10};
        run_xfer(q, 0, "empty");
        q = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_xfer(q, 0, "stream");
        q = '{8'hFE, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_xfer(q, 0, "wrap");

        // reset in the middle of the payload
        @(posedge clk); #1;
        dl_active = 1'b1;
        @(posedge clk); #1;
        q = '{8'h00, 8'h03, 8'h5A, 8'hA5};
        byte_valid = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            byte_data = q[i];
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                if (byte_ready) break;
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mrst_we", dma_we, 0);
        chk("mrst_ready", byte_ready, 0);
        chk("mrst_hold", cpu_hold, 0);
        chk("mrst_error", error, 0);
        chk("mrst_addr", dma_addr, 0);
        chk("mrst_din", dma_din, 0);
        dl_active = 1'b0;
        obs.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_nostrobe", obs.size(), 0);
        chk("mrst_hold2", cpu_hold, 0);
        q = '{8'h40, 8'h02, 8'h99};
        run_xfer(q, 1, "after_rst");

        for (int t = 0; t < 40; t++) begin
            q.delete();
            mode = $urandom_range(0, 4);
            case (mode)
                0: ld = $urandom_range(16'h0400, 16'h7F00);
                1: ld = 16'h7FF8 + $urandom_range(0, 12);
                2: ld = 16'hFFF8 + $urandom_range(0, 7);
                default: ld = $urandom_range(0, 16'hFFFF);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                np = -$urandom_range(1, 2);
            end else begin
                np = $urandom_range(0, 10);
            end
            if (np >= -1) q.push_back(8'(ld));
            if (np >= 0) q.push_back(8'(ld >> 8));
            for (int i = 0; i < np; i++) q.push_back(8'($urandom));
            run_xfer(q, $urandom_range(0, 3), $sformatf("rnd%0d", t));
        end

        chk("overlap", n_overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
